// File: rtl/db_mem_responder_pkg.sv
// Shared data-bus encodings and responder state type for db_mem_responder.
// LFSR helpers exist only when DB_MEM_RANDWAIT_EN is defined.
package db_mem_responder_pkg;

    localparam logic [1:0] MEM_ACCESS_NONE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_R    = 2'd1;
    localparam logic [1:0] MEM_ACCESS_W    = 2'd2;
    localparam logic [1:0] MEM_ACCESS_X    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

`ifdef DB_MEM_RANDWAIT_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting left.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
`endif

endpackage

// File: rtl/db_mem_array.sv
// Single-port synchronous word RAM: write on we, read data registered every cycle.
module db_mem_array #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/db_mem_responder.sv
// CPU data-bus target: word RAM with a programmable wait before the db_ready pulse.
// Define DB_MEM_RANDWAIT_EN to add a pseudo-random 0..3 cycle extra wait per request.
module db_mem_responder
    import db_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  logic [1:0]  db_accessType,
    input  logic [31:0] db_dataOut,
    output logic [31:0] db_dataIn,
    output logic        db_ready,
    output logic        db_err
);

    localparam int unsigned CNT_W = 5;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next, total_wait;
    logic [31:0]           word_off;
    logic                  bus_in_range, accept, we;
    logic [ADDR_WIDTH-1:0] bus_idx, idx_q, ram_idx;
    logic                  in_range_q, read_q;
    logic [31:0]           ram_rdata;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign word_off     = (db_addr - BASE_ADDR) >> 2;
    assign bus_in_range = (word_off >> ADDR_WIDTH) == 32'd0;
    assign bus_idx      = word_off[ADDR_WIDTH-1:0];
    assign accept       = res && (state == ST_IDLE) && (db_accessType != MEM_ACCESS_NONE);
    assign we           = accept && (db_accessType == MEM_ACCESS_W) && bus_in_range;
    assign ram_idx      = (state == ST_IDLE) ? bus_idx : idx_q;

`ifdef DB_MEM_RANDWAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!res) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign total_wait = CNT_W'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
    assign total_wait = CNT_W'(WAIT_CYCLES);
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (total_wait == '0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = total_wait;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                idx_q      <= bus_idx;
                in_range_q <= bus_in_range;
                read_q     <= (db_accessType == MEM_ACCESS_R) || (db_accessType == MEM_ACCESS_X);
            end
        end
    end

    db_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .idx  (ram_idx),
        .wdata(db_dataOut),
        .rdata(ram_rdata)
    );

    // RAM output is registered on the edge entering RESP; it is only exposed during RESP.
    assign db_dataIn = (state == ST_RESP && in_range_q && read_q) ? ram_rdata : '0;
    assign db_ready  = (state == ST_RESP);
    assign db_err    = (state == ST_RESP) && !in_range_q;

endmodule
